// File: rtl/sr_ff_cmd_driver.sv
// Request driver for one SR flip-flop: takes HOLD/RESET/SET/TOGGLE requests, pulses s or r,
// then checks q. Optional macro SR_CHECK_BAR_EN also checks that q_bar_in is the complement of q_in.
`timescale 1ns/1ps
module sr_ff_cmd_driver #(
    parameter int HOLD_CYCLES = 1,
    parameter int TIMEOUT     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    output logic       req_ready,
    input  logic       q_in,
    input  logic       q_bar_in,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_WAIT} state_t;

    localparam int HC_W = $clog2(HOLD_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT);

    state_t          state_q, state_d;
    logic            s_q, s_d, r_q, r_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            req_ready_q, req_ready_d;
    logic            tgt_q, tgt_d;
    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            q_smp_q, q_smp_d;

    logic accept, tgt_new, q_match, wait_ok, bar_fail, wait_tmo;

`ifdef SR_CHECK_BAR_EN
    logic q_bar_smp_q;
    logic mis_q, mis_d;
    logic bar_bad;
`else
    logic unused_q_bar;
    assign unused_q_bar = q_bar_in;
`endif

    assign accept  = (state_q == ST_IDLE) & req_valid & req_ready_q;
    assign q_smp_d = q_in;

    always_comb begin
        case (req_op)
            2'b00:   tgt_new = q_in;
            2'b01:   tgt_new = 1'b0;
            2'b10:   tgt_new = 1'b1;
            default: tgt_new = ~q_in;
        endcase
    end

    // q is judged from a registered sample, so the response check sees q one cycle late
    assign q_match = (q_smp_q == tgt_q);
`ifdef SR_CHECK_BAR_EN
    assign bar_bad  = q_match & (q_bar_smp_q == q_smp_q);
    assign wait_ok  = q_match & ~bar_bad;
    assign bar_fail = bar_bad & mis_q;
`else
    assign wait_ok  = q_match;
    assign bar_fail = 1'b0;
`endif
    assign wait_tmo = (wait_cnt_q >= TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            req_ready_q <= 1'b0;
            tgt_q       <= 1'b0;
            hold_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            q_smp_q     <= 1'b0;
`ifdef SR_CHECK_BAR_EN
            q_bar_smp_q <= 1'b0;
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            r_q         <= r_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            req_ready_q <= req_ready_d;
            tgt_q       <= tgt_d;
            hold_cnt_q  <= hold_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            q_smp_q     <= q_smp_d;
`ifdef SR_CHECK_BAR_EN
            q_bar_smp_q <= q_bar_in;
            mis_q       <= mis_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (q_in != tgt_new) ? ST_DRIVE : ST_WAIT;
            ST_DRIVE: if (hold_cnt_q == HOLD_LAST) state_d = ST_WAIT;
            ST_WAIT:  if (wait_ok || bar_fail || wait_tmo) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_d         = 1'b0;
        r_d         = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        req_ready_d = req_ready_q;
        tgt_d       = tgt_q;
        hold_cnt_d  = hold_cnt_q;
        wait_cnt_d  = wait_cnt_q;
`ifdef SR_CHECK_BAR_EN
        mis_d       = mis_q;
`endif
        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    err_code_d  = 2'b00;
                    tgt_d       = tgt_new;
                    hold_cnt_d  = '0;
                    wait_cnt_d  = '0;
`ifdef SR_CHECK_BAR_EN
                    mis_d       = 1'b0;
`endif
                    if (q_in != tgt_new) begin
                        s_d = tgt_new;
                        r_d = ~tgt_new;
                    end
                end
            end
            ST_DRIVE: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    wait_cnt_d = '0;
`ifdef SR_CHECK_BAR_EN
                    mis_d      = 1'b0;
`endif
                end else begin
                    s_d        = s_q;
                    r_d        = r_q;
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (wait_ok) begin
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    req_ready_d = 1'b1;
                end else if (bar_fail) begin
                    err_d       = 1'b1;
                    err_code_d  = 2'b10;
                    busy_d      = 1'b0;
                    req_ready_d = 1'b1;
                end else if (wait_tmo) begin
                    err_d       = 1'b1;
                    err_code_d  = 2'b01;
                    busy_d      = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    wait_cnt_d  = (wait_cnt_q == TO_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
                end
`ifdef SR_CHECK_BAR_EN
                mis_d = bar_bad;
`endif
            end
            default: ;
        endcase
    end

    assign s         = s_q;
    assign r         = r_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign req_ready = req_ready_q;

endmodule

// File: tb/tb_sr_ff_cmd_driver.sv
// Directed bench for sr_ff_cmd_driver driving a behavioural synchronous SR flip-flop.
`timescale 1ns/1ps
module tb_sr_ff_cmd_driver;
    logic       clk = 1'b0;
    logic       rst, req_valid, req_ready, q_in, q_bar_in;
    logic [1:0] req_op, err_code;
    logic       s, r, busy, done, err;
    logic       ff_q, ff_clr, bar_force;

    int checks = 0;
    int errors = 0;
    int lat, sc, rc;
    bit d, e, seen;

    sr_ff_cmd_driver #(.HOLD_CYCLES(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
        .q_in(q_in), .q_bar_in(q_bar_in), .s(s), .r(r), .busy(busy), .done(done),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ff_clr)           ff_q <= 1'b0;
        else if (s && !r)     ff_q <= 1'b1;
        else if (r && !s)     ff_q <= 1'b0;
    end
    assign q_in     = ff_q;
    assign q_bar_in = bar_force ? ff_q : ~ff_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("sr_exclusive", 32'(s & r), 32'd0);
    endtask

    task automatic run_req(input logic [1:0] op, input bit hold_valid, output int l,
                           output bit got_done, output bit got_err, output int s_cyc, output int r_cyc);
        l = 0; got_done = 0; got_err = 0; s_cyc = 0; r_cyc = 0;
        req_valid = 1'b1;
        req_op    = op;
        tick();
        s_cyc += int'(s);
        r_cyc += int'(r);
        if (!hold_valid) req_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            s_cyc += int'(s);
            r_cyc += int'(r);
            if (done || err) begin
                l = i; got_done = done; got_err = err;
                break;
            end
        end
        req_valid = 1'b0;
        $display("txn op=%0d lat=%0d done=%0d err=%0d code=%0d s_cyc=%0d r_cyc=%0d q=%0d",
                 op, l, got_done, got_err, err_code, s_cyc, r_cyc, ff_q);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_op = 2'b00; ff_clr = 1'b1; bar_force = 1'b0;
        tick(); tick();
        chk("rst_s", 32'(s), 0);            chk("rst_r", 32'(r), 0);
        chk("rst_done", 32'(done), 0);      chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);      chk("rst_ready", 32'(req_ready), 0);
        chk("rst_code", 32'(err_code), 0);
        rst = 1'b1; ff_clr = 1'b0;
        tick();
        chk("ready_after_release", 32'(req_ready), 1);
        chk("q_start", 32'(ff_q), 0);

        // SET from q=0: one-cycle s pulse, done three edges after accept
        run_req(2'b10, 0, lat, d, e, sc, rc);
        chk("set_lat", lat, 3); chk("set_done", 32'(d), 1); chk("set_err", 32'(e), 0);
        chk("set_s_cyc", sc, 1); chk("set_r_cyc", rc, 0); chk("set_q", 32'(ff_q), 1);

        run_req(2'b11, 0, lat, d, e, sc, rc);
        chk("tog1_lat", lat, 3); chk("tog1_done", 32'(d), 1);
        chk("tog1_s_cyc", sc, 0); chk("tog1_r_cyc", rc, 1); chk("tog1_q", 32'(ff_q), 0);
        run_req(2'b11, 0, lat, d, e, sc, rc);
        chk("tog2_lat", lat, 3); chk("tog2_s_cyc", sc, 1); chk("tog2_r_cyc", rc, 0);
        chk("tog2_q", 32'(ff_q), 1);

        // already-at-target and HOLD: no pulse, done one edge after accept
        run_req(2'b10, 0, lat, d, e, sc, rc);
        chk("set_noop_lat", lat, 1); chk("set_noop_done", 32'(d), 1);
        chk("set_noop_s_cyc", sc, 0); chk("set_noop_r_cyc", rc, 0);
        run_req(2'b00, 1, lat, d, e, sc, rc);
        chk("hold_lat", lat, 1); chk("hold_done", 32'(d), 1); chk("hold_s_cyc", sc + rc, 0);
        tick();
        chk("hold_single_busy", 32'(busy), 0); chk("hold_single_ready", 32'(req_ready), 1);
        chk("hold_single_done", 32'(done), 0);

        run_req(2'b01, 0, lat, d, e, sc, rc);
        chk("reset_lat", lat, 3); chk("reset_r_cyc", rc, 1); chk("reset_q", 32'(ff_q), 0);

        // flip-flop stuck in its own reset: timeout after 8 WAIT cycles
        ff_clr = 1'b1;
        run_req(2'b10, 0, lat, d, e, sc, rc);
        chk("tmo_lat", lat, 9); chk("tmo_err", 32'(e), 1); chk("tmo_done", 32'(d), 0);
        chk("tmo_code", 32'(err_code), 1);
        tick();
        chk("tmo_err_pulse", 32'(err), 0); chk("tmo_code_hold", 32'(err_code), 1);
        ff_clr = 1'b0;
        run_req(2'b00, 0, lat, d, e, sc, rc);
        chk("code_clear_lat", lat, 1); chk("code_clear", 32'(err_code), 0);

        // async abort in the middle of DRIVE
        req_valid = 1'b1; req_op = 2'b10;
        tick();
        chk("abort_s_before", 32'(s), 1);
        rst = 1'b0;
        #1;
        chk("abort_s_async", 32'(s), 0); chk("abort_busy_async", 32'(busy), 0);
        req_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen |= (done | err);
        end
        chk("abort_no_pulse", 32'(seen), 0); chk("abort_ready", 32'(req_ready), 1);
        chk("abort_q", 32'(ff_q), 0);
        $display("txn abort mid-DRIVE seen_done_or_err=%0d", seen);

`ifdef SR_CHECK_BAR_EN
        bar_force = 1'b1;
        run_req(2'b10, 0, lat, d, e, sc, rc);
        chk("bar_lat", lat, 4); chk("bar_err", 32'(e), 1); chk("bar_code", 32'(err_code), 2);
        bar_force = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
